// File: rtl/jtag_tap_sequencer.sv
// Command-driven JTAG TAP sequencer: turns RESET / SHIFT_IR / SHIFT_DR / IDLE
// commands into registered TMS/TDI sequences and captures TDO into rsp_data.
module jtag_tap_sequencer #(
  parameter int MAX_LEN          = 32,
  parameter int RESET_TMS_CYCLES = 5
) (
  input  logic               tck,
  input  logic               trst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [5:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_err,
  output logic               busy,
  output logic [2:0]         dbg_state
);

  // Handshake: a command transfers on a rising tck edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, and rsp_valid is a single-cycle pulse with no ready.
  typedef enum logic [2:0] {
    S_IDLE, S_TO_RTI, S_PRE, S_SHIFT, S_POST, S_RUN, S_RST, S_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_RESET = 2'b00, OP_SHIFT_IR = 2'b01, OP_SHIFT_DR = 2'b10, OP_IDLE = 2'b11
  } op_e;

  localparam logic [6:0] MAX_LEN_W = 7'(MAX_LEN);
  localparam logic [5:0] RST_LAST  = 6'(RESET_TMS_CYCLES - 1);

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [5:0]           len_q, len_d;
  logic [MAX_LEN-1:0]   data_q, data_d;
  logic [5:0]           cnt_q, cnt_d;
  logic                 in_tlr_q, in_tlr_d;
  logic                 tms_q, tms_d;
  logic                 tdi_q, tdi_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [MAX_LEN-1:0]   rsp_data_q, rsp_data_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 busy_q, busy_d;

  logic                 accept;
  logic                 cmd_err;
  op_e                  cur_op;
  logic [5:0]           cur_len;
  logic                 launch;
  logic                 go_done;
  logic [5:0]           pre_last;

  assign accept   = (state_q == S_IDLE) && cmd_valid && cmd_ready_q;
  assign cmd_err  = (cmd_op[1] ^ cmd_op[0]) &&
                    ((cmd_len == 6'd0) || ({1'b0, cmd_len} > MAX_LEN_W));
  assign cur_op   = accept ? op_e'(cmd_op) : op_q;
  assign cur_len  = accept ? cmd_len : len_q;
  assign pre_last = (op_q == OP_SHIFT_IR) ? 6'd3 : 6'd2;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    len_d       = len_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    in_tlr_d    = in_tlr_q;
    tms_d       = tms_q;
    tdi_d       = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    launch      = 1'b0;
    go_done     = 1'b0;

    // tms_d/tdi_d describe the bit driven in the cycle after this edge.
    case (state_q)
      S_IDLE: begin
        tms_d = in_tlr_q;
        if (accept) begin
          op_d       = op_e'(cmd_op);
          len_d      = cmd_len;
          data_d     = cmd_data;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          if (cmd_err) begin
            rsp_err_d = 1'b1;
            go_done   = 1'b1;
          end else if (op_e'(cmd_op) == OP_RESET) begin
            state_d = S_RST;
            cnt_d   = '0;
            tms_d   = 1'b1;
          end else if (in_tlr_q) begin
            state_d = S_TO_RTI;
            tms_d   = 1'b0;
          end else begin
            launch = 1'b1;
          end
        end
      end
      S_TO_RTI: begin
        in_tlr_d = 1'b0;
        launch   = 1'b1;
      end
      S_PRE: begin
        if (cnt_q == pre_last) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          tms_d   = (len_q == 6'd1);
          tdi_d   = data_q[0];
          data_d  = data_q >> 1;
        end else begin
          cnt_d = cnt_q + 6'd1;
          tms_d = (op_q == OP_SHIFT_IR) && (cnt_q == 6'd0);
        end
      end
      S_SHIFT: begin
        // The target consumes bit cnt_q at this edge, so its TDO belongs to bit cnt_q.
        rsp_data_d = rsp_data_q | ({{(MAX_LEN-1){1'b0}}, tdo} << cnt_q);
        if (cnt_q == len_q - 6'd1) begin
          state_d = S_POST;
          cnt_d   = '0;
          tms_d   = 1'b1;
        end else begin
          cnt_d  = cnt_q + 6'd1;
          tdi_d  = data_q[0];
          data_d = data_q >> 1;
          tms_d  = (cnt_q + 6'd2 == len_q);
        end
      end
      S_POST: begin
        if (cnt_q == 6'd0) begin
          cnt_d = 6'd1;
          tms_d = 1'b0;
        end else begin
          go_done = 1'b1;
        end
      end
      S_RUN: begin
        if (cnt_q == len_q - 6'd1) begin
          go_done = 1'b1;
        end else begin
          cnt_d = cnt_q + 6'd1;
          tms_d = 1'b0;
        end
      end
      S_RST: begin
        if (cnt_q == RST_LAST) begin
          in_tlr_d = 1'b1;
          go_done  = 1'b1;
        end else begin
          cnt_d = cnt_q + 6'd1;
          tms_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        tms_d   = in_tlr_q;
      end
      default: state_d = S_IDLE;
    endcase

    // Reached Run-Test/Idle: start the shift preamble or the idle clocks.
    if (launch) begin
      if (cur_op == OP_IDLE) begin
        if (cur_len == 6'd0) begin
          go_done = 1'b1;
        end else begin
          state_d = S_RUN;
          cnt_d   = '0;
          tms_d   = 1'b0;
        end
      end else begin
        state_d = S_PRE;
        cnt_d   = '0;
        tms_d   = 1'b1;
      end
    end

    if (go_done) begin
      state_d     = S_DONE;
      rsp_valid_d = 1'b1;
      tms_d       = in_tlr_d;
      tdi_d       = 1'b0;
    end

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_RESET;
      len_q       <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      in_tlr_q    <= 1'b1;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      len_q       <= len_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      in_tlr_q    <= in_tlr_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule
